// File: rtl/alu_serial_seq_if.sv
// alu_serial_seq_if: request/response bundle for the bit-serial ALU controller.
interface alu_serial_seq_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             busy;
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero, busy
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero, busy
    );
endinterface

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial WIDTH-bit ALU that runs one alu_1bit slice LSB-first, one bit per cycle.
module alu_1bit (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       r,
    output logic       cout
);
    logic bx;
    always_comb begin
        bx   = op == 2'b11 ? ~b : b;
        r    = op == 2'b00 ? a & b : op == 2'b01 ? a | b : a ^ bx ^ cin;
        cout = op[1] ? (a & bx) | (cin & (a ^ bx)) : 1'b0;
    end
endmodule

module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    alu_serial_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sr;
    logic [1:0]       sop;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             r;
    logic             c;
    logic [WIDTH-1:0] word;

    alu_1bit u_slice (.a(sa[0]), .b(sb[0]), .cin(carry), .op(sop), .r(r), .cout(c));

    assign word         = {r, sr};
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            carry        <= 1'b0;
            cnt          <= '0;
            bus.result   <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b1;
        end else if (state == IDLE) begin
            if (bus.in_valid) begin
                sa    <= bus.a;
                sb    <= bus.b;
                sop   <= bus.op;
                carry <= bus.op == 2'b11;
                cnt   <= '0;
                state <= RUN;
            end
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sr    <= word[WIDTH-1:1];
            carry <= c;
            cnt   <= cnt + 1'b1;
            // on the MSB bit, carry is that bit's carry-in, so cin XOR cout is signed overflow
            if (cnt == LAST) begin
                state        <= DONE;
                bus.result   <= word;
                bus.cout     <= c;
                bus.overflow <= sop[1] & (carry ^ c);
                bus.zero     <= word == '0;
            end
        end else begin
            state <= bus.out_ready ? IDLE : DONE;
        end
    end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: vector table, hand corner cases and randomized ops against an arithmetic model.
module tb_alu_serial_seq;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_serial_seq_if #(.WIDTH(W)) bus();
    alu_serial_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int passed = 0;
    int total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        r = '0; c = 1'b0; v = 1'b0; s = '0;
        if (op == 2'b00) r = a & b;
        else if (op == 2'b01) r = a | b;
        else if (op == 2'b10) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r = a - b;
            c = a >= b;
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {r, c, v, r == '0};
    endfunction

    // Called at a negedge with the DUT idle; returns {result,cout,overflow,zero} and cycles to out_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                          input int hold, input bit toggle, input string name,
                          output logic [W+2:0] got, output int lat);
        bit busy_ok;
        bit stable;
        busy_ok = 1'b1;
        stable = 1'b1;
        bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (!bus.busy || bus.in_ready) busy_ok = 1'b0;
            if (toggle) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.op = 2'($urandom_range(0, 3));
                bus.in_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        if (lat >= 100) chk({name, "_timeout"}, 64'(lat), 64'(W));
        if (!bus.busy) busy_ok = 1'b0;
        got = {bus.result, bus.cout, bus.overflow, bus.zero};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ({bus.result, bus.cout, bus.overflow, bus.zero} !== got || !bus.out_valid || bus.in_ready) stable = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_lat"}, 64'(lat), 64'(W));
        chk({name, "_busy"}, 64'(busy_ok), 64'd1);
        chk({name, "_stable"}, 64'(stable), 64'd1);
        chk({name, "_idle"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    endtask

    vec_t tv[8];
    logic [W+2:0] got;
    int lat;

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        chk("rst_flags", {bus.result, bus.cout, bus.overflow, bus.zero}, {8'h00, 3'b001});
        rst_n = 1'b1;
        @(negedge clk);

        tv[0] = '{8'h3C, 8'h05, 2'b10, 8'h41, 1'b0, 1'b0, 1'b0};
        tv[1] = '{8'h7F, 8'h01, 2'b10, 8'h80, 1'b0, 1'b1, 1'b0};
        tv[2] = '{8'hFF, 8'h01, 2'b10, 8'h00, 1'b1, 1'b0, 1'b1};
        tv[3] = '{8'h05, 8'h05, 2'b11, 8'h00, 1'b1, 1'b0, 1'b1};
        tv[4] = '{8'h00, 8'h01, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0};
        tv[5] = '{8'h80, 8'h01, 2'b11, 8'h7F, 1'b1, 1'b1, 1'b0};
        tv[6] = '{8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0, 1'b0, 1'b0};
        tv[7] = '{8'hF0, 8'h3C, 2'b01, 8'hFC, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(tv[i].a, tv[i].b, tv[i].op, (i == 0) ? 5 : 0, i[0], $sformatf("vec%0d", i), got, lat);
            chk($sformatf("vec%0d_out", i), got, {tv[i].r, tv[i].c, tv[i].v, tv[i].z});
        end

        begin
            int acc[$];
            bus.a = 8'h01; bus.b = 8'h02; bus.op = 2'b10; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            for (int i = 0; i < 3 * (W + 2) && acc.size() < 2; i++) begin
                if (bus.in_ready) acc.push_back(i);
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            chk("b2b_count", 64'(acc.size()), 64'd2);
            if (acc.size() == 2) chk("b2b_spacing", 64'(acc[1] - acc[0]), 64'(W + 2));
            repeat (W + 3) @(negedge clk);
            bus.out_ready = 1'b0;
            chk("b2b_result", 64'(bus.result), 64'h03);
        end

        begin
            bit quiet;
            quiet = 1'b1;
            bus.a = 8'h55; bus.b = 8'h22; bus.op = 2'b10; bus.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk("abort_state", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
            chk("abort_flags", {bus.result, bus.cout, bus.overflow, bus.zero}, {8'h00, 3'b001});
            for (int i = 0; i < W + 2; i++) begin
                if (bus.out_valid) quiet = 1'b0;
                @(negedge clk);
            end
            chk("abort_quiet", 64'(quiet), 64'd1);
            run_op(8'h01, 8'h01, 2'b10, 0, 1'b0, "fresh", got, lat);
            chk("fresh_out", got, {8'h02, 3'b000});
        end

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [1:0]   rop;
            ra = W'($urandom);
            rb = W'($urandom);
            rop = 2'($urandom_range(0, 3));
            run_op(ra, rb, rop, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i), got, lat);
            chk($sformatf("rand%0d_out", i), got, model(ra, rb, rop));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
